// File: rtl/ibr128_arbiter.sv
// ibr128_arbiter: shares one IBR128 core between NREQ requesters.
//
// Grants round-robin per message. The grant stays with one requester from the
// first to the last block of its message, so the core's chaining state is
// never interleaved between requesters. The accepted operands are latched and
// the core is given a one-cycle start pulse. A watchdog bounds the wait for
// the result, and the result goes back to the owning requester over
// valid/ready.
//
// Ports:
//   Clk, RstN                    clock, async active-low reset
//   req_valid/ready/first/last   per-requester block handshake and framing
//   req_data/encrypt/som/ob/iv/key0/key1  per-requester operands (flat, lane i
//                                at [W*i +: W])
//   resp_valid/resp_ready        per-requester result handshake
//   resp_data                    result block (shared, qualified by resp_valid)
//   err                          one-cycle watchdog-abort pulse per requester
//   busy                         not idle, or a message lock is held
//   core_*                       operands / start / result of the IBR128 core

// Per-requester slice: decodes grant and response select for one lane, and
// packs that lane's operand fields into one vector for the capture mux.
module ibr128_arb_lane #(
  parameter int IDX = 0,
  parameter int IW  = 1,
  parameter int OPW = 292
) (
  input  logic          valid,
  input  logic          encrypt,
  input  logic [1:0]    som,
  input  logic          ob,
  input  logic [31:0]   iv,
  input  logic [63:0]   key0,
  input  logic [63:0]   key1,
  input  logic [127:0]  data,
  input  logic          grant_en,
  input  logic [IW-1:0] grant_idx,
  input  logic          resp_en,
  input  logic [IW-1:0] owner,
  output logic          ready,
  output logic          resp_valid,
  output logic [OPW-1:0] op
);
  assign ready      = grant_en & valid & (grant_idx == IW'(IDX));
  assign resp_valid = resp_en & (owner == IW'(IDX));
  // Field order matches op_t in the top level.
  assign op         = {encrypt, som, ob, iv, key0, key1, data};
endmodule

module ibr128_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                Clk,
  input  logic                RstN,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ-1:0]     req_first,
  input  logic [NREQ-1:0]     req_last,
  input  logic [NREQ*128-1:0] req_data,
  input  logic [NREQ-1:0]     req_encrypt,
  input  logic [NREQ*2-1:0]   req_som,
  input  logic [NREQ-1:0]     req_ob,
  input  logic [NREQ*32-1:0]  req_iv,
  input  logic [NREQ*64-1:0]  req_key0,
  input  logic [NREQ*64-1:0]  req_key1,
  output logic [NREQ-1:0]     resp_valid,
  input  logic [NREQ-1:0]     resp_ready,
  output logic [127:0]        resp_data,
  output logic [NREQ-1:0]     err,
  output logic                busy,
  output logic                core_enable,
  output logic                core_sa,
  output logic                core_encrypt,
  output logic [1:0]          core_som,
  output logic                core_ob,
  output logic [31:0]         core_iv,
  output logic [63:0]         core_key0,
  output logic [63:0]         core_key1,
  output logic [127:0]        core_plaintext,
  input  logic [127:0]        core_ciphertext,
  input  logic                core_cipher_ready
);
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW = 16;

  typedef struct packed {
    logic         encrypt;
    logic [1:0]   som;
    logic         ob;
    logic [31:0]  iv;
    logic [63:0]  key0;
    logic [63:0]  key1;
    logic [127:0] data;
  } op_t;

  localparam int OPW = $bits(op_t);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            lock_q, lock_d;
  logic            last_q, last_d;
  op_t             op_q, op_d;
  logic            en_q, en_d;
  logic            sa_q, sa_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic [127:0]    resp_data_q, resp_data_d;
  logic [NREQ-1:0] err_q, err_d;

  logic            cand_vld;
  logic [IW-1:0]   cand_idx;
  logic [NREQ-1:0][OPW-1:0] lane_op;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Candidate selection. While a message is locked only its owner may be
  // granted; otherwise scan upward from rr_ptr. The descending loop lets the
  // smallest offset from rr_ptr win. RstN gates the combinational ready so it
  // is low for the whole time reset is asserted.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    if (state_q == S_IDLE && RstN) begin
      if (lock_q) begin
        cand_vld = req_valid[owner_q];
        cand_idx = owner_q;
      end else begin
        for (int k = NREQ - 1; k >= 0; k--) begin
          if (req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
            cand_vld = 1'b1;
            cand_idx = IW'((int'(rr_ptr_q) + k) % NREQ);
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    ibr128_arb_lane #(.IDX(g), .IW(IW), .OPW(OPW)) u_lane (
      .valid      (req_valid[g]),
      .encrypt    (req_encrypt[g]),
      .som        (req_som[2*g +: 2]),
      .ob         (req_ob[g]),
      .iv         (req_iv[32*g +: 32]),
      .key0       (req_key0[64*g +: 64]),
      .key1       (req_key1[64*g +: 64]),
      .data       (req_data[128*g +: 128]),
      .grant_en   (cand_vld),
      .grant_idx  (cand_idx),
      .resp_en    (state_q == S_RESP),
      .owner      (owner_q),
      .ready      (req_ready[g]),
      .resp_valid (resp_valid[g]),
      .op         (lane_op[g])
    );
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    last_d      = last_q;
    op_d        = op_q;
    en_d        = 1'b0;
    sa_d        = 1'b0;
    wd_d        = wd_q;
    resp_data_d = resp_data_q;
    err_d       = '0;
    case (state_q)
      S_IDLE: begin
        if (cand_vld) begin
          owner_d = cand_idx;
          op_d    = lane_op[cand_idx];
          last_d  = req_last[cand_idx];
          // Start pulse and SA are registered so they appear exactly in ISSUE.
          en_d    = 1'b1;
          sa_d    = req_first[cand_idx];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Counting down to zero gives TIMEOUT WAIT cycles after the start cycle.
        wd_d    = WDW'(TIMEOUT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_cipher_ready) begin
          // Checked before expiry, so a result on the last cycle still counts.
          resp_data_d = core_ciphertext;
          state_d     = S_RESP;
        end else if (wd_q == '0) begin
          err_d[owner_q] = 1'b1;
          lock_d         = 1'b0;
          rr_ptr_d       = next_idx(owner_q);
          state_d        = S_IDLE;
        end else begin
          wd_d = wd_q - 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready[owner_q]) begin
          if (last_q) begin
            lock_d   = 1'b0;
            rr_ptr_d = next_idx(owner_q);
          end else begin
            lock_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      last_q      <= 1'b0;
      op_q        <= '0;
      en_q        <= 1'b0;
      sa_q        <= 1'b0;
      wd_q        <= '0;
      resp_data_q <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      last_q      <= last_d;
      op_q        <= op_d;
      en_q        <= en_d;
      sa_q        <= sa_d;
      wd_q        <= wd_d;
      resp_data_q <= resp_data_d;
      err_q       <= err_d;
    end
  end

  assign resp_data      = resp_data_q;
  assign err            = err_q;
  assign busy           = (state_q != S_IDLE) | lock_q;
  assign core_enable    = en_q;
  assign core_sa        = sa_q;
  assign core_encrypt   = op_q.encrypt;
  assign core_som       = op_q.som;
  assign core_ob        = op_q.ob;
  assign core_iv        = op_q.iv;
  assign core_key0      = op_q.key0;
  assign core_key1      = op_q.key1;
  assign core_plaintext = op_q.data;

endmodule

// File: tb/tb_ibr128_arbiter.sv
// Testbench for ibr128_arbiter (NREQ=2, TIMEOUT=4): table of grant vectors plus
// hand-written sequences for stall, watchdog, expiry-cycle result and reset.
// A simple core stand-in answers core_enable after a chosen latency; expected
// results are computed from the requester's own operands at accept time.
module tb_ibr128_arbiter;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 4;

  logic                Clk = 1'b0;
  logic                RstN = 1'b1;
  logic [NREQ-1:0]     req_valid, req_ready, req_first, req_last;
  logic [NREQ*128-1:0] req_data;
  logic [NREQ-1:0]     req_encrypt, req_ob;
  logic [NREQ*2-1:0]   req_som;
  logic [NREQ*32-1:0]  req_iv;
  logic [NREQ*64-1:0]  req_key0, req_key1;
  logic [NREQ-1:0]     resp_valid, resp_ready, err;
  logic [127:0]        resp_data;
  logic                busy, core_enable, core_sa, core_encrypt, core_ob;
  logic [1:0]          core_som;
  logic [31:0]         core_iv;
  logic [63:0]         core_key0, core_key1;
  logic [127:0]        core_plaintext, core_ciphertext;
  logic                core_cipher_ready;

  ibr128_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .RstN(RstN),
    .req_valid(req_valid), .req_ready(req_ready), .req_first(req_first), .req_last(req_last),
    .req_data(req_data), .req_encrypt(req_encrypt), .req_som(req_som), .req_ob(req_ob),
    .req_iv(req_iv), .req_key0(req_key0), .req_key1(req_key1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .err(err), .busy(busy), .core_enable(core_enable), .core_sa(core_sa),
    .core_encrypt(core_encrypt), .core_som(core_som), .core_ob(core_ob), .core_iv(core_iv),
    .core_key0(core_key0), .core_key1(core_key1), .core_plaintext(core_plaintext),
    .core_ciphertext(core_ciphertext), .core_cipher_ready(core_cipher_ready)
  );

  always #5 Clk = ~Clk;

  typedef struct { int id; logic [127:0] data; } exp_t;
  typedef struct {
    logic [1:0] valid; logic [1:0] first; logic [1:0] last;
    int exp_g; logic exp_sa; int lat;
  } vec_t;

  exp_t sb[$];
  int n_vec = 0, n_bad = 0;
  int cyc = 0;
  int core_lat = 1, en_cnt = 0, en_cyc = 0, err_cnt = 0;
  logic last_sa = 1'b0;
  logic [NREQ-1:0] hold = '0;
  logic [127:0] ct;
  exp_t rsp_e;

  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [63:0] k0,
      input logic [63:0] k1, input logic [31:0] iv, input logic enc, input logic [1:0] som,
      input logic ob);
    logic [127:0] x;
    x = d ^ {k0, k1};
    x = enc ? {x[126:0], x[127]} : {x[0], x[127:1]};
    x[31:0] = x[31:0] ^ iv;
    x[1:0]  = x[1:0] ^ som;
    x[127]  = x[127] ^ ob;
    return x;
  endfunction

  function automatic logic [127:0] exp_of(input int g);
    return core_fn(req_data[128*g +: 128], req_key0[64*g +: 64], req_key1[64*g +: 64],
                   req_iv[32*g +: 32], req_encrypt[g], req_som[2*g +: 2], req_ob[g]);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input int i, input bit v, input bit f, input bit l);
    req_valid[i] = v;
    req_first[i] = f;
    req_last[i]  = l;
    req_data[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
    req_key0[64*i +: 64]   = {$urandom, $urandom};
    req_key1[64*i +: 64]   = {$urandom, $urandom};
    req_iv[32*i +: 32]     = $urandom;
    req_encrypt[i]         = 1'($urandom_range(0, 1));
    req_som[2*i +: 2]      = 2'($urandom_range(0, 3));
    req_ob[i]              = 1'($urandom_range(0, 1));
  endtask

  // Entered at +1 after an edge; returns at +1 after the accept edge.
  task automatic wait_accept(output int got, input bit push);
    exp_t e;
    got = -1;
    for (int c = 0; c < 40 && got < 0; c++) begin
      #1;
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i] && got < 0) got = i;
      if (got >= 0 && push) begin
        e.id = got; e.data = exp_of(got); sb.push_back(e);
      end
      @(posedge Clk); #1;
    end
    if (got >= 0) req_valid[got] = 1'b0;
    else begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout: got no req_ready, required one within 40 cycles");
    end
  endtask

  task automatic wait_drain();
    int c = 0;
    while (sb.size() != 0 && c < 60) begin @(posedge Clk); #1; c++; end
    if (sb.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain_timeout: got %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"},  128'(req_ready), '0);
    chk({tag, "_resp_valid"}, 128'(resp_valid), '0);
    chk({tag, "_resp_data"},  resp_data, '0);
    chk({tag, "_err"},        128'(err), '0);
    chk({tag, "_busy"},       128'(busy), '0);
    chk({tag, "_core_en_sa"}, 128'({core_enable, core_sa}), '0);
    chk({tag, "_core_ctl"},   128'({core_encrypt, core_som, core_ob, core_iv}), '0);
    chk({tag, "_core_keys"},  {core_key0, core_key1}, '0);
    chk({tag, "_core_pt"},    core_plaintext, '0);
  endtask

  initial forever begin @(posedge Clk); cyc = cyc + 1; end

  // Core stand-in: answers core_enable after core_lat cycles (0 = never).
  initial begin
    core_cipher_ready = 1'b0;
    core_ciphertext   = '0;
    forever begin
      @(posedge Clk); #1;
      if (core_enable === 1'b1) begin
        en_cnt++; en_cyc = cyc; last_sa = core_sa;
        ct = core_fn(core_plaintext, core_key0, core_key1, core_iv, core_encrypt, core_som, core_ob);
        if (core_lat > 0) begin
          repeat (core_lat) @(posedge Clk);
          #1 core_ciphertext = ct; core_cipher_ready = 1'b1;
          @(posedge Clk);
          #1 core_cipher_ready = 1'b0; core_ciphertext = ~ct;
        end
      end
    end
  end

  // Response taker and scoreboard check.
  initial begin
    resp_ready = '0;
    forever begin
      @(posedge Clk);
      #1 resp_ready = ~hold;
      #1;
      if (|err) err_cnt++;
      for (int i = 0; i < NREQ; i++) begin
        if (resp_valid[i] && resp_ready[i]) begin
          if (sb.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL resp_unexpected: got resp_valid[%0d], required none", i);
          end else begin
            rsp_e = sb.pop_front();
            chk("resp_id", 128'(i), 128'(rsp_e.id));
            chk("resp_data", resp_data, rsp_e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [10];
    int got, c, bad, e0;
    logic [127:0] d0;

    tbl[0] = '{2'b11, 2'b11, 2'b11, 0, 1'b1, 1};
    tbl[1] = '{2'b11, 2'b11, 2'b11, 1, 1'b1, 2};
    tbl[2] = '{2'b11, 2'b11, 2'b11, 0, 1'b1, 3};
    tbl[3] = '{2'b11, 2'b11, 2'b11, 1, 1'b1, 1};
    tbl[4] = '{2'b11, 2'b11, 2'b10, 0, 1'b1, 2};  // req0 opens a 3-block message
    tbl[5] = '{2'b11, 2'b10, 2'b10, 0, 1'b0, 1};  // middle block, req1 must wait
    tbl[6] = '{2'b11, 2'b10, 2'b11, 0, 1'b0, 3};  // last block releases lock
    tbl[7] = '{2'b11, 2'b11, 2'b11, 1, 1'b1, 1};
    tbl[8] = '{2'b10, 2'b11, 2'b11, 1, 1'b1, 2};
    tbl[9] = '{2'b01, 2'b00, 2'b01, 0, 1'b0, 4};  // first=0 unlocked; result on expiry cycle

    req_valid = '0; req_first = '0; req_last = '0;
    for (int i = 0; i < NREQ; i++) load(i, 1'b1, 1'b1, 1'b1);
    #2 RstN = 1'b0;
    repeat (3) @(posedge Clk);
    #2 check_reset("rst");
    req_valid = '0;
    RstN = 1'b1;
    @(posedge Clk); #1;

    for (int n = 0; n < 10; n++) begin
      core_lat = tbl[n].lat;
      for (int i = 0; i < NREQ; i++) load(i, tbl[n].valid[i], tbl[n].first[i], tbl[n].last[i]);
      wait_accept(got, 1'b1);
      chk($sformatf("v%0d_grant", n), 128'(got), 128'(tbl[n].exp_g));
      wait_drain();
      chk($sformatf("v%0d_sa", n), 128'(last_sa), 128'(tbl[n].exp_sa));
    end
    chk("table_no_err", 128'(err_cnt), '0);

    // Requester 0 holds off its response for 20 cycles.
    hold = 2'b01; core_lat = 2;
    load(0, 1'b1, 1'b1, 1'b1); load(1, 1'b0, 1'b1, 1'b1);
    wait_accept(got, 1'b1);
    chk("stall_grant", 128'(got), 128'd0);
    load(1, 1'b1, 1'b1, 1'b1);
    c = 0;
    while (resp_valid[0] !== 1'b1 && c < 20) begin @(posedge Clk); #1; c++; end
    chk("stall_resp_valid", 128'(resp_valid), 128'd1);
    d0 = resp_data; e0 = en_cnt; bad = 0;
    repeat (20) begin
      @(posedge Clk); #1;
      if (resp_valid !== 2'b01 || resp_data !== d0 || req_ready !== 2'b00 || core_enable !== 1'b0)
        bad++;
    end
    chk("stall_stable_cycles", 128'(bad), '0);
    chk("stall_no_enable", 128'(en_cnt), 128'(e0));
    hold = '0;
    wait_drain();
    wait_accept(got, 1'b1);
    chk("after_stall_grant", 128'(got), 128'd1);
    wait_drain();

    // Result arriving on the watchdog's last cycle is delivered, no error.
    core_lat = TIMEOUT; e0 = err_cnt;
    load(0, 1'b1, 1'b1, 1'b1); load(1, 1'b0, 1'b1, 1'b1);
    wait_accept(got, 1'b1);
    wait_drain();
    chk("expiry_no_err", 128'(err_cnt), 128'(e0));

    // Watchdog abort inside a locked message.
    core_lat = 1;
    load(0, 1'b1, 1'b1, 1'b0); load(1, 1'b0, 1'b1, 1'b1);
    wait_accept(got, 1'b1);
    chk("to_first_grant", 128'(got), 128'd0);
    wait_drain();
    load(1, 1'b1, 1'b1, 1'b1);
    core_lat = 0;
    load(0, 1'b1, 1'b0, 1'b0);
    wait_accept(got, 1'b0);
    chk("to_mid_grant", 128'(got), 128'd0);
    #1 c = 0;
    while (err === '0 && c < 30) begin @(posedge Clk); #2; c++; end
    chk("to_err_vec", 128'(err), 128'd1);
    chk("to_err_delay", 128'(cyc - en_cyc), 128'd5);
    chk("to_next_grant", 128'(req_ready), 128'd2);
    if (req_ready[1] === 1'b1) begin
      rsp_e.id = 1; rsp_e.data = exp_of(1); sb.push_back(rsp_e);
    end
    core_lat = 1;
    @(posedge Clk); #1 req_valid[1] = 1'b0;
    #1 chk("to_err_pulse_len", 128'(err), '0);
    wait_drain();

    // Reset while a locked message is waiting on the core.
    core_lat = 1;
    load(0, 1'b1, 1'b1, 1'b0); load(1, 1'b0, 1'b1, 1'b1);
    wait_accept(got, 1'b1);
    chk("rst_first_grant", 128'(got), 128'd0);
    wait_drain();
    load(1, 1'b1, 1'b1, 1'b1);
    core_lat = 0;
    load(0, 1'b1, 1'b0, 1'b0);
    wait_accept(got, 1'b0);
    chk("rst_mid_grant", 128'(got), 128'd0);
    repeat (2) @(posedge Clk);
    #1 RstN = 1'b0;
    #1 check_reset("mid");
    req_valid[0] = 1'b0;
    @(posedge Clk);
    #1 RstN = 1'b1; core_lat = 1;
    wait_accept(got, 1'b1);
    chk("rst_after_grant", 128'(got), 128'd1);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
